da_shift_accum: RTL and testbench

//   Bit-serial distributed-arithmetic accumulator; sits directly downstream of the LUT stage.

---
 rtl/da_shift_accum_if.sv | 32 +++
 rtl/da_shift_accum.sv | 95 +++++++++
 tb/tb_da_shift_accum.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/da_shift_accum_if.sv
// Valid/ready bundle between the LUT stage, the DA accumulator and the result consumer.
//   in_valid / in_ready / lut_in        : plane partial-sum input handshake
//   out_valid / out_ready / acc_out     : finished dot-product output handshake
//   plane_idx                           : index of the next plane the accumulator expects
// master = producer/consumer side, slave = accumulator side.
interface da_shift_accum_if #(
    parameter int K            = 32,
    parameter int DATA_WIDTH_B = 16,
    parameter int X_WIDTH      = 8
);
    localparam int LUT_W = DATA_WIDTH_B + $clog2(K) + 1;
    localparam int OUT_W = LUT_W + X_WIDTH;
    localparam int IDX_W = $clog2(X_WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [LUT_W-1:0] lut_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] acc_out;
    logic [IDX_W-1:0] plane_idx;

    modport master (
        output in_valid, lut_in, out_ready,
        input  in_ready, out_valid, acc_out, plane_idx
    );

    modport slave (
        input  in_valid, lut_in, out_ready,
        output in_ready, out_valid, acc_out, plane_idx
    );
endinterface

// File: rtl/da_shift_accum.sv
// Bit-serial distributed-arithmetic accumulator.
// Takes one signed LUT partial sum per activation bit-plane (LSB plane first),
// shift-accumulates X_WIDTH planes and subtracts the MSB (sign) plane, giving a
// two's-complement dot product presented on a valid/ready output.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, discards any partial frame
//   bus : da_shift_accum_if.slave (input handshake, output handshake, plane_idx)
module da_shift_accum #(
    parameter int K            = 32,
    parameter int DATA_WIDTH_B = 16,
    parameter int X_WIDTH      = 8
) (
    input  logic               clk,
    input  logic               rst,
    da_shift_accum_if.slave    bus
);
    localparam int LUT_W = DATA_WIDTH_B + $clog2(K) + 1;
    localparam int OUT_W = LUT_W + X_WIDTH;
    localparam int IDX_W = $clog2(X_WIDTH);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    in_ready_c;
    logic                    out_valid_c;
    logic                    accept;
    logic                    last_plane;
    logic signed [OUT_W-1:0] lut_ext;
    logic signed [OUT_W-1:0] term;
    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] acc_out_q;
    logic [IDX_W-1:0]        plane_idx_q;

    // Sign-extend to full result width before shifting so no bits are lost.
    assign lut_ext    = {{X_WIDTH{bus.lut_in[LUT_W-1]}}, bus.lut_in};
    assign term       = lut_ext <<< plane_idx_q;
    assign last_plane = (plane_idx_q == IDX_W'(X_WIDTH - 1));
    assign accept     = bus.in_valid && in_ready_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_plane) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // The sign plane carries weight -2^(X_WIDTH-1), so it is subtracted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            acc_out_q   <= '0;
            plane_idx_q <= '0;
        end else if (accept) begin
            if (last_plane) begin
                acc_out_q   <= acc - term;
                acc         <= '0;
                plane_idx_q <= '0;
            end else begin
                acc         <= acc + term;
                plane_idx_q <= plane_idx_q + IDX_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.acc_out   = acc_out_q;
    assign bus.plane_idx = plane_idx_q;
endmodule

// File: tb/tb_da_shift_accum.sv
module tb_da_shift_accum;
    localparam int K            = 32;
    localparam int DATA_WIDTH_B = 16;
    localparam int X_WIDTH      = 8;
    localparam int LUT_W        = DATA_WIDTH_B + $clog2(K) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int passed = 0;
    int total  = 0;

    da_shift_accum_if #(.K(K), .DATA_WIDTH_B(DATA_WIDTH_B), .X_WIDTH(X_WIDTH)) bus ();

    da_shift_accum #(.K(K), .DATA_WIDTH_B(DATA_WIDTH_B), .X_WIDTH(X_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint acc_val();
        return longint'($signed(bus.acc_out));
    endfunction

    // Reference: activation bit p has weight 2^p, except the sign bit which weighs -2^(X_WIDTH-1).
    function automatic longint model(input longint vals[X_WIDTH]);
        longint s = 0;
        for (int p = 0; p < X_WIDTH; p++) begin
            if (p == X_WIDTH - 1) s -= vals[p] * (longint'(1) << p);
            else                  s += vals[p] * (longint'(1) << p);
        end
        return s;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic push(input longint v);
        int n = 0;
        logic [LUT_W-1:0] w;
        w = v[LUT_W-1:0];
        bus.in_valid = 1'b1;
        bus.lut_in   = w;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", longint'(bus.in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input longint vals[X_WIDTH], input longint exp,
                             input int gmin, input int gmax, input bit tied);
        bus.out_ready = tied;
        for (int p = 0; p < X_WIDTH; p++) begin
            push(vals[p]);
            if (p < X_WIDTH - 1) begin
                check("ov_early", longint'(bus.out_valid), 0);
                repeat ($urandom_range(gmin, gmax)) @(negedge clk);
                check("plane_idx", longint'(bus.plane_idx), p + 1);
            end
        end
        check("ov_latency", longint'(bus.out_valid), 1);
        check("acc_out", acc_val(), exp);
        check("ir_hold", longint'(bus.in_ready), 0);
        check("idx_wrap", longint'(bus.plane_idx), 0);
        if (!tied) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("ov_stable", longint'(bus.out_valid), 1);
                check("acc_stable", acc_val(), exp);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("ov_clear", longint'(bus.out_valid), 0);
        check("ir_back", longint'(bus.in_ready), 1);
    endtask

    initial begin
        longint v[X_WIDTH];
        longint r;

        bus.in_valid  = 1'b0;
        bus.lut_in    = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_acc", acc_val(), 0);
        check("rst_ov", longint'(bus.out_valid), 0);
        check("rst_idx", longint'(bus.plane_idx), 0);
        check("rst_ir", longint'(bus.in_ready), 1);

        // All ones, out_ready tied high: 127 - 128
        foreach (v[i]) v[i] = 1;
        run_frame(v, -1, 0, 0, 1'b1);

        // Single LSB plane, single sign plane
        foreach (v[i]) v[i] = 0;
        v[0] = 3;
        run_frame(v, 3, 0, 0, 1'b0);
        foreach (v[i]) v[i] = 0;
        v[7] = 5;
        run_frame(v, -640, 0, 0, 1'b0);

        // in_valid toggling every cycle gives the same result as back-to-back
        foreach (v[i]) v[i] = -2;
        run_frame(v, 2, 1, 1, 1'b0);
        run_frame(v, 2, 0, 0, 1'b0);

        // Result held with out_ready low while the next plane waits upstream
        foreach (v[i]) v[i] = 2;
        bus.out_ready = 1'b0;
        for (int p = 0; p < X_WIDTH; p++) push(v[p]);
        check("bp_acc", acc_val(), -2);
        bus.in_valid = 1'b1;
        bus.lut_in   = LUT_W'(7);
        repeat (3) begin
            @(negedge clk);
            check("bp_ov", longint'(bus.out_valid), 1);
            check("bp_acc_stable", acc_val(), -2);
            check("bp_ir", longint'(bus.in_ready), 0);
            check("bp_idx", longint'(bus.plane_idx), 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_ir_after", longint'(bus.in_ready), 1);
        check("bp_idx_after", longint'(bus.plane_idx), 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_idx_taken", longint'(bus.plane_idx), 1);
        for (int p = 1; p < X_WIDTH; p++) push(0);
        check("bp_next_acc", acc_val(), 7);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-frame
        for (int p = 0; p < 4; p++) push(1);
        check("ar_idx_before", longint'(bus.plane_idx), 4);
        #3 rst = 1'b1;
        #1;
        check("ar_acc", acc_val(), 0);
        check("ar_ov", longint'(bus.out_valid), 0);
        check("ar_idx", longint'(bus.plane_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        foreach (v[i]) v[i] = 1;
        run_frame(v, -1, 0, 0, 1'b0);

        // Extremes of the signed LUT range
        foreach (v[i]) v[i] = -(longint'(1) << 21);
        v[7] = (longint'(1) << 21) - 1;
        run_frame(v, -(longint'(1) << 21) * 127 - ((longint'(1) << 21) - 1) * 128, 0, 0, 1'b0);
        foreach (v[i]) v[i] = (longint'(1) << 21) - 1;
        v[7] = -(longint'(1) << 21);
        run_frame(v, model(v), 0, 1, 1'b1);

        // Random frames against the model
        for (int f = 0; f < 1000; f++) begin
            foreach (v[i]) begin
                r = longint'($urandom_range(0, (1 << LUT_W) - 1)) - (longint'(1) << (LUT_W - 1));
                if ($urandom_range(0, 15) == 0) r = -(longint'(1) << (LUT_W - 1));
                if ($urandom_range(0, 15) == 0) r = (longint'(1) << (LUT_W - 1)) - 1;
                v[i] = r;
            end
            run_frame(v, model(v), 0, 2, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
